csr_sequencer: RTL and testbench
================================

Name: csr_sequencer

Overview:
Initiator side of the machine-level CSR unit port (op / addr_exception / write_value in, read_value / fault out one cycle later). Accepts SYSTEM-class requests from the execute stage: CSR instructions, MRET and traps. Drives exactly one CSR op per request, captures the registered result and returns either an rd writeback value or a PC redirect. A CSR access that faults, or an illegal funct3, is converted into an illegal-instruction exception issued to the CSR unit.

Parameters:
ILLEGAL_INSN_CAUSE, 5'h02, cause (bit4 = interrupt flag, bits3:0 = code) issued when a CSR access faults or funct3 is illegal.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; request accepted when valid && ready
req_kind  input  2  00 = CSR instruction, 01 = MRET, 10 = trap, 11 = treated as illegal
req_funct3  input  3  CSR instruction funct3
req_csr  input  12  CSR address
req_rs1_value  input  32  rs1 operand
req_zimm  input  5  immediate for the CSRR*I forms
req_rd_zero  input  1  rd index is x0
req_pc  input  32  PC of the instruction, or trap PC
req_cause  input  5  trap cause for kind 10
rsp_valid  output  1  response present; held until rsp_ready
rsp_ready  input  1  response accepted
rsp_rd_write  output  1  write rsp_rd_value to rd
rsp_rd_value  output  32  CSR old value
rsp_redirect  output  1  next PC = rsp_pc
rsp_pc  output  32  redirect target
csr_op  output  3  to CSR unit
csr_addr_exception  output  12  to CSR unit
csr_write_value  output  32  to CSR unit
csr_read_value  input  32  from CSR unit, valid the cycle after the op
csr_fault  input  1  from CSR unit, valid the cycle after the op

Behaviour:
- The CSR unit executes its op every cycle. Outside ISSUE/TRAP_ISSUE the sequencer drives idle op 3'b010 with addr 0 and wdata 0. This op leaves all CSR state unchanged; its fault output is ignored.
- All csr_* and rsp_* outputs are registered.
- Reset values: csr_op = 3'b010, csr_addr_exception = 0, csr_write_value = 0, rsp_valid = 0, rsp_rd_write = 0, rsp_redirect = 0, rsp_rd_value = 0, rsp_pc = 0, state = IDLE (so req_ready = 1 on the first cycle after reset).
- Reset mid-operation: return to IDLE and drop rsp_valid. The CSR unit shares the reset, so no cleanup op is issued.
- Decode, with funct3 mapping to op and write value:
  - 001 → 101, rs1_value
  - 010 → 110, rs1_value
  - 011 → 111, rs1_value
  - 101 → 101, zext(zimm)
  - 110 → 110, zext(zimm)
  - 111 → 111, zext(zimm)
  - 000/100 → illegal
- States: IDLE, ISSUE, CAPTURE, TRAP_ISSUE, TRAP_CAPTURE, RESPOND.
- Transitions:
  - IDLE: on accept, latch the request.
    - Legal CSR instruction or MRET → ISSUE.
    - Trap, illegal funct3 or kind 11 → TRAP_ISSUE, with cause = req_cause for traps, else ILLEGAL_INSN_CAUSE.
  - ISSUE: drive the op. CSR instruction uses addr = req_csr and the decoded wdata; MRET uses op 001 with addr 0 and wdata 0. → CAPTURE.
  - CAPTURE:
    - csr_fault = 1 on a CSR instruction → TRAP_ISSUE with ILLEGAL_INSN_CAUSE.
    - Otherwise register the response → RESPOND.
    - CSR instruction response: rd_write = !req_rd_zero, rd_value = csr_read_value, redirect = 0.
    - MRET response: redirect = 1, rsp_pc = csr_read_value, rd_write = 0.
    - csr_fault is ignored for MRET.
  - TRAP_ISSUE: op 000, addr_exception = {7'b0, cause}, wdata = latched req_pc. → TRAP_CAPTURE.
  - TRAP_CAPTURE: response redirect = 1, rsp_pc = csr_read_value, rd_write = 0. → RESPOND.
  - RESPOND: rsp_valid = 1, outputs stable while !rsp_ready. On rsp_ready → IDLE.
- Latency from the accept cycle to the first rsp_valid cycle:
  - CSR instruction / MRET / trap / illegal funct3: 3 cycles.
  - CSR access that faults: 5 cycles.
- Throughput: one request in flight; next accept no earlier than the cycle after the response handshake.
- A faulting CSR write has no architectural effect; rd is not written.

Decomposition:
- Shared package csr_pkg holds:
  - op encodings: EXC 000, MRET 001, RW 101, RS 110, RC 111, IDLE 010;
  - CSR address constants 0x300/0x304/0x305/0x341/0x342/0x344;
  - the req_kind enum and the state enum.
- One natural sub-module: csr_insn_decode, combinational funct3/rs1/zimm → {op, write_value, illegal}.

Test Plan:
- Reset → next cycle: req_ready = 1, csr_op = 010, rsp_valid = 0.
- CSRRW 0x300, rs1 = 0x8, rd ≠ x0 → ISSUE cycle op 101 / addr 0x300 / wdata 8; rsp at +3 with rd_write = 1, rd_value = 0. Follow-up CSRRS 0x300 with rs1 = 0 → rd_value = 0x8.
- CSRRW 0x305 (mtvec) rs1 = 1, pc = 0x100 → op 101 fault, then op 000 / addr 0x002 / wdata 0x100; rsp at +5 with redirect = 1, pc = 0x10 (handler at 0x10), rd_write = 0. Follow-up reads: mcause = 0x2, mepc = 0x100.
- Trap cause 5'h1B, pc = 0x200 → op 000 / addr 0x01B; rsp redirect to 0x10. Then MRET → op 001; rsp redirect pc = 0x200.
- funct3 = 000 at pc 0x40 → no RW/RS/RC op issued; op 000 / addr 0x002 / wdata 0x40; rsp at +3 with redirect.
- Hold rsp_ready low 4 cycles → rsp_* stable, req_ready = 0, csr_op = 010. Assert reset during ISSUE → next cycle IDLE, rsp_valid = 0, csr_op = 010.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR request sequencer: CSR unit op codes,
// machine CSR addresses, request kinds and sequencer states.
package csr_pkg;

  localparam logic [2:0] OP_EXC  = 3'b000;
  localparam logic [2:0] OP_MRET = 3'b001;
  localparam logic [2:0] OP_IDLE = 3'b010;
  localparam logic [2:0] OP_RW   = 3'b101;
  localparam logic [2:0] OP_RS   = 3'b110;
  localparam logic [2:0] OP_RC   = 3'b111;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  typedef enum logic [1:0] {
    KIND_CSR  = 2'b00,
    KIND_MRET = 2'b01,
    KIND_TRAP = 2'b10,
    KIND_RSVD = 2'b11
  } req_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_TRAP_ISSUE,
    ST_TRAP_CAPTURE,
    ST_RESPOND
  } state_e;

  // The exception op carries the cause in the address field.
  function automatic logic [11:0] exc_addr(input logic [4:0] cause);
    return {7'b0, cause};
  endfunction

endpackage

// File: rtl/csr_insn_decode.sv
// Combinational decode of a CSR instruction's funct3 into the CSR unit op
// and the value to combine with the CSR (rs1 or zero-extended zimm).
module csr_insn_decode
  import csr_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_value,
  input  logic [4:0]  zimm,
  output logic [2:0]  op,
  output logic [31:0] write_value,
  output logic        illegal
);

  always_comb begin
    op          = OP_IDLE;
    illegal     = 1'b0;
    // funct3[2] selects the immediate forms.
    write_value = funct3[2] ? {27'b0, zimm} : rs1_value;
    case (funct3[1:0])
      2'b01:   op = OP_RW;
      2'b10:   op = OP_RS;
      2'b11:   op = OP_RC;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/csr_sequencer.sv
// Sequences one SYSTEM request (CSR insn, MRET, trap) through the CSR unit
// port and returns an rd writeback or PC redirect; faults become exceptions.
module csr_sequencer
  import csr_pkg::*;
#(
  parameter logic [4:0] ILLEGAL_INSN_CAUSE = 5'h02
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr,
  input  logic [31:0] req_rs1_value,
  input  logic [4:0]  req_zimm,
  input  logic        req_rd_zero,
  input  logic [31:0] req_pc,
  input  logic [4:0]  req_cause,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_rd_write,
  output logic [31:0] rsp_rd_value,
  output logic        rsp_redirect,
  output logic [31:0] rsp_pc,
  output logic [2:0]  csr_op,
  output logic [11:0] csr_addr_exception,
  output logic [31:0] csr_write_value,
  input  logic [31:0] csr_read_value,
  input  logic        csr_fault
);

  state_e      state_reg, state_next;

  logic [2:0]  csr_op_reg, csr_op_next;
  logic [11:0] csr_addr_reg, csr_addr_next;
  logic [31:0] csr_wdata_reg, csr_wdata_next;

  logic        rsp_valid_reg, rsp_valid_next;
  logic        rsp_rd_write_reg, rsp_rd_write_next;
  logic [31:0] rsp_rd_value_reg, rsp_rd_value_next;
  logic        rsp_redirect_reg, rsp_redirect_next;
  logic [31:0] rsp_pc_reg, rsp_pc_next;

  req_kind_e   kind_reg;
  logic        rd_zero_reg;
  logic [31:0] pc_reg;

  logic [2:0]  dec_op;
  logic [31:0] dec_write_value;
  logic        dec_illegal;
  logic        accept;

  csr_insn_decode u_decode (
    .funct3      (req_funct3),
    .rs1_value   (req_rs1_value),
    .zimm        (req_zimm),
    .op          (dec_op),
    .write_value (dec_write_value),
    .illegal     (dec_illegal)
  );

  assign req_ready = (state_reg == ST_IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      csr_op_reg       <= OP_IDLE;
      csr_addr_reg     <= '0;
      csr_wdata_reg    <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_rd_write_reg <= 1'b0;
      rsp_rd_value_reg <= '0;
      rsp_redirect_reg <= 1'b0;
      rsp_pc_reg       <= '0;
    end else begin
      state_reg        <= state_next;
      csr_op_reg       <= csr_op_next;
      csr_addr_reg     <= csr_addr_next;
      csr_wdata_reg    <= csr_wdata_next;
      rsp_valid_reg    <= rsp_valid_next;
      rsp_rd_write_reg <= rsp_rd_write_next;
      rsp_rd_value_reg <= rsp_rd_value_next;
      rsp_redirect_reg <= rsp_redirect_next;
      rsp_pc_reg       <= rsp_pc_next;
    end
  end

  // Request context needed after the accept cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      kind_reg    <= KIND_CSR;
      rd_zero_reg <= 1'b0;
      pc_reg      <= '0;
    end else if (accept) begin
      kind_reg    <= req_kind_e'(req_kind);
      rd_zero_reg <= req_rd_zero;
      pc_reg      <= req_pc;
    end
  end

  // Outputs are registered, so each transition loads the values the
  // destination state must present on the following cycle.
  always_comb begin
    state_next        = state_reg;
    csr_op_next       = OP_IDLE;
    csr_addr_next     = '0;
    csr_wdata_next    = '0;
    rsp_valid_next    = rsp_valid_reg;
    rsp_rd_write_next = rsp_rd_write_reg;
    rsp_rd_value_next = rsp_rd_value_reg;
    rsp_redirect_next = rsp_redirect_reg;
    rsp_pc_next       = rsp_pc_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (req_kind_e'(req_kind))
            KIND_CSR: begin
              if (dec_illegal) begin
                state_next     = ST_TRAP_ISSUE;
                csr_op_next    = OP_EXC;
                csr_addr_next  = exc_addr(ILLEGAL_INSN_CAUSE);
                csr_wdata_next = req_pc;
              end else begin
                state_next     = ST_ISSUE;
                csr_op_next    = dec_op;
                csr_addr_next  = req_csr;
                csr_wdata_next = dec_write_value;
              end
            end
            KIND_MRET: begin
              state_next  = ST_ISSUE;
              csr_op_next = OP_MRET;
            end
            KIND_TRAP: begin
              state_next     = ST_TRAP_ISSUE;
              csr_op_next    = OP_EXC;
              csr_addr_next  = exc_addr(req_cause);
              csr_wdata_next = req_pc;
            end
            default: begin
              state_next     = ST_TRAP_ISSUE;
              csr_op_next    = OP_EXC;
              csr_addr_next  = exc_addr(ILLEGAL_INSN_CAUSE);
              csr_wdata_next = req_pc;
            end
          endcase
        end
      end

      ST_ISSUE: state_next = ST_CAPTURE;

      ST_CAPTURE: begin
        if (kind_reg == KIND_MRET) begin
          state_next        = ST_RESPOND;
          rsp_valid_next    = 1'b1;
          rsp_rd_write_next = 1'b0;
          rsp_rd_value_next = '0;
          rsp_redirect_next = 1'b1;
          rsp_pc_next       = csr_read_value;
        end else if (csr_fault) begin
          // The faulting access left CSR state untouched; raise the exception.
          state_next     = ST_TRAP_ISSUE;
          csr_op_next    = OP_EXC;
          csr_addr_next  = exc_addr(ILLEGAL_INSN_CAUSE);
          csr_wdata_next = pc_reg;
        end else begin
          state_next        = ST_RESPOND;
          rsp_valid_next    = 1'b1;
          rsp_rd_write_next = !rd_zero_reg;
          rsp_rd_value_next = csr_read_value;
          rsp_redirect_next = 1'b0;
          rsp_pc_next       = '0;
        end
      end

      ST_TRAP_ISSUE: state_next = ST_TRAP_CAPTURE;

      ST_TRAP_CAPTURE: begin
        state_next        = ST_RESPOND;
        rsp_valid_next    = 1'b1;
        rsp_rd_write_next = 1'b0;
        rsp_rd_value_next = '0;
        rsp_redirect_next = 1'b1;
        rsp_pc_next       = csr_read_value;
      end

      ST_RESPOND: begin
        if (rsp_ready) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b0;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign csr_op             = csr_op_reg;
  assign csr_addr_exception = csr_addr_reg;
  assign csr_write_value    = csr_wdata_reg;
  assign rsp_valid          = rsp_valid_reg;
  assign rsp_rd_write       = rsp_rd_write_reg;
  assign rsp_rd_value       = rsp_rd_value_reg;
  assign rsp_redirect       = rsp_redirect_reg;
  assign rsp_pc             = rsp_pc_reg;

endmodule

// File: tb/tb_csr_sequencer.sv
// Scoreboard bench for csr_sequencer with a small behavioural CSR unit
// (mtvec = 0x10, writes leaving mtvec[1:0] nonzero fault).
module tb_csr_sequencer;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_kind = '0;
  logic [2:0]  req_funct3 = '0;
  logic [11:0] req_csr = '0;
  logic [31:0] req_rs1_value = '0;
  logic [4:0]  req_zimm = '0;
  logic        req_rd_zero = 1'b0;
  logic [31:0] req_pc = '0;
  logic [4:0]  req_cause = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_rd_write;
  logic [31:0] rsp_rd_value;
  logic        rsp_redirect;
  logic [31:0] rsp_pc;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr_exception;
  logic [31:0] csr_write_value;
  logic [31:0] csr_read_value;
  logic        csr_fault;

  csr_sequencer #(.ILLEGAL_INSN_CAUSE(5'h02)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_funct3(req_funct3), .req_csr(req_csr), .req_rs1_value(req_rs1_value),
    .req_zimm(req_zimm), .req_rd_zero(req_rd_zero), .req_pc(req_pc),
    .req_cause(req_cause),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_write(rsp_rd_write),
    .rsp_rd_value(rsp_rd_value), .rsp_redirect(rsp_redirect), .rsp_pc(rsp_pc),
    .csr_op(csr_op), .csr_addr_exception(csr_addr_exception),
    .csr_write_value(csr_write_value), .csr_read_value(csr_read_value),
    .csr_fault(csr_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural CSR unit: executes csr_op every cycle, result registered.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mip;
  logic [31:0] model_old, model_new;
  logic        model_known;

  always_comb begin
    model_known = 1'b1;
    model_old   = '0;
    case (csr_addr_exception)
      CSR_MSTATUS: model_old = m_mstatus;
      CSR_MIE:     model_old = m_mie;
      CSR_MTVEC:   model_old = m_mtvec;
      CSR_MEPC:    model_old = m_mepc;
      CSR_MCAUSE:  model_old = m_mcause;
      CSR_MIP:     model_old = m_mip;
      default:     model_known = 1'b0;
    endcase
    case (csr_op)
      OP_RW:   model_new = csr_write_value;
      OP_RS:   model_new = model_old | csr_write_value;
      OP_RC:   model_new = model_old & ~csr_write_value;
      default: model_new = model_old;
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      m_mstatus <= '0; m_mie <= '0; m_mtvec <= 32'h10;
      m_mepc <= '0; m_mcause <= '0; m_mip <= '0;
      csr_read_value <= '0; csr_fault <= 1'b0;
    end else begin
      csr_read_value <= '0;
      csr_fault      <= 1'b0;
      if (csr_op == OP_RW || csr_op == OP_RS || csr_op == OP_RC) begin
        if (!model_known) csr_fault <= 1'b1;
        else if (csr_addr_exception == CSR_MTVEC && model_new[1:0] != 2'b00) begin
          csr_fault      <= 1'b1;
          csr_read_value <= model_old;
        end else begin
          csr_read_value <= model_old;
          case (csr_addr_exception)
            CSR_MSTATUS: m_mstatus <= model_new;
            CSR_MIE:     m_mie     <= model_new;
            CSR_MTVEC:   m_mtvec   <= model_new;
            CSR_MEPC:    m_mepc    <= model_new;
            CSR_MCAUSE:  m_mcause  <= model_new;
            default:     m_mip     <= model_new;
          endcase
        end
      end else if (csr_op == OP_EXC) begin
        m_mepc         <= csr_write_value;
        m_mcause       <= {27'b0, csr_addr_exception[4:0]};
        csr_read_value <= m_mtvec;
      end else if (csr_op == OP_MRET) begin
        csr_read_value <= m_mepc;
      end
    end
  end

  typedef struct packed {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
  } op_exp_t;

  typedef struct packed {
    logic        rd_write;
    logic [31:0] rd_value;
    logic        redirect;
    logic [31:0] pc;
    int          latency;
    int          accept_cyc;
  } rsp_exp_t;

  op_exp_t  op_q[$];
  rsp_exp_t rsp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_rsp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out, got none, expected event (cycle %0d)", name, cyc);
  endtask

  task automatic push_op(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wdata);
    op_exp_t e;
    e.op = op; e.addr = addr; e.wdata = wdata;
    op_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] kind, input logic [2:0] f3, input logic [11:0] csr,
                      input logic [31:0] rs1, input logic [4:0] zimm, input logic rdz,
                      input logic [31:0] pc, input logic [4:0] cause, input int hold,
                      input logic x_rdw, input logic [31:0] x_rdv, input logic x_redir,
                      input logic [31:0] x_pc, input int x_lat);
    rsp_exp_t e;
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) begin timeout_fail("req_ready"); return; end
    #1;
    req_kind = kind; req_funct3 = f3; req_csr = csr; req_rs1_value = rs1;
    req_zimm = zimm; req_rd_zero = rdz; req_pc = pc; req_cause = cause;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    e.rd_write = x_rdw; e.rd_value = x_rdv; e.redirect = x_redir; e.pc = x_pc;
    e.latency = x_lat; e.accept_cyc = cyc;
    rsp_q.push_back(e);
    @(posedge clk); #1 req_valid = 1'b0;
    if (hold > 0) begin
      t = 0;
      @(negedge clk);
      while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
      if (!rsp_valid) timeout_fail("rsp_valid_hold");
      repeat (hold - 1) @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) timeout_fail("rsp_handshake");
  endtask

  initial begin
    fork
      // Monitors: check CSR ops and responses as the DUT presents them.
      begin : monitor
        bit seen_first;
        rsp_exp_t r;
        op_exp_t o;
        seen_first = 1'b0;
        forever begin
          @(negedge clk);
          if (csr_op != OP_IDLE) begin
            if (op_q.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL unexpected_op: got op=%b addr=0x%0h, expected none", csr_op, csr_addr_exception);
            end else begin
              o = op_q.pop_front();
              check("csr_op", 64'(csr_op), 64'(o.op));
              check("csr_addr", 64'(csr_addr_exception), 64'(o.addr));
              check("csr_wdata", 64'(csr_write_value), 64'(o.wdata));
            end
          end
          if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL unexpected_rsp: got rsp_valid=1, expected 0");
            end else begin
              r = rsp_q[0];
              if (!seen_first) begin
                check("latency", 64'(cyc - r.accept_cyc), 64'(r.latency));
                seen_first = 1'b1;
              end
              check("rsp_rd_write", 64'(rsp_rd_write), 64'(r.rd_write));
              check("rsp_rd_value", 64'(rsp_rd_value), 64'(r.rd_value));
              check("rsp_redirect", 64'(rsp_redirect), 64'(r.redirect));
              check("rsp_pc", 64'(rsp_pc), 64'(r.pc));
              if (!rsp_ready) begin
                check("hold_req_ready", 64'(req_ready), 64'(0));
                check("hold_csr_op", 64'(csr_op), 64'(OP_IDLE));
              end else begin
                void'(rsp_q.pop_front());
                seen_first = 1'b0;
                n_rsp++;
                $display("rsp %0d: rd_write=%0d rd_value=0x%08h redirect=%0d pc=0x%08h",
                         n_rsp, rsp_rd_write, rsp_rd_value, rsp_redirect, rsp_pc);
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'(1));
    check("reset_csr_op", 64'(csr_op), 64'(OP_IDLE));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_redirect", 64'(rsp_redirect), 64'(0));

    // CSRRW mstatus <- 8, then CSRRS read-back
    push_op(OP_RW, 12'h300, 32'h8);
    send(2'b00, 3'b001, 12'h300, 32'h8, 5'd0, 1'b0, 32'h0, 5'd0, 0, 1'b1, 32'h0, 1'b0, 32'h0, 3);
    push_op(OP_RS, 12'h300, 32'h0);
    send(2'b00, 3'b010, 12'h300, 32'h0, 5'd0, 1'b0, 32'h4, 5'd0, 0, 1'b1, 32'h8, 1'b0, 32'h0, 3);
    // Faulting mtvec write becomes an illegal-instruction exception
    push_op(OP_RW, 12'h305, 32'h1);
    push_op(OP_EXC, 12'h002, 32'h100);
    send(2'b00, 3'b001, 12'h305, 32'h1, 5'd0, 1'b0, 32'h100, 5'd0, 0, 1'b0, 32'h0, 1'b1, 32'h10, 5);
    push_op(OP_RS, 12'h342, 32'h0);
    send(2'b00, 3'b010, 12'h342, 32'h0, 5'd0, 1'b0, 32'h104, 5'd0, 0, 1'b1, 32'h2, 1'b0, 32'h0, 3);
    push_op(OP_RS, 12'h341, 32'h0);
    send(2'b00, 3'b010, 12'h341, 32'h0, 5'd0, 1'b0, 32'h108, 5'd0, 0, 1'b1, 32'h100, 1'b0, 32'h0, 3);
    // Trap then MRET
    push_op(OP_EXC, 12'h01B, 32'h200);
    send(2'b10, 3'b000, 12'h000, 32'h0, 5'd0, 1'b0, 32'h200, 5'h1B, 0, 1'b0, 32'h0, 1'b1, 32'h10, 3);
    push_op(OP_MRET, 12'h000, 32'h0);
    send(2'b01, 3'b000, 12'h000, 32'h0, 5'd0, 1'b0, 32'h14, 5'd0, 0, 1'b0, 32'h0, 1'b1, 32'h200, 3);
    // Illegal funct3 000 / 100 and reserved kind
    push_op(OP_EXC, 12'h002, 32'h40);
    send(2'b00, 3'b000, 12'h300, 32'h7, 5'd0, 1'b0, 32'h40, 5'd0, 0, 1'b0, 32'h0, 1'b1, 32'h10, 3);
    push_op(OP_EXC, 12'h002, 32'h44);
    send(2'b11, 3'b001, 12'h300, 32'h7, 5'd0, 1'b0, 32'h44, 5'h1F, 0, 1'b0, 32'h0, 1'b1, 32'h10, 3);
    push_op(OP_EXC, 12'h002, 32'h80);
    send(2'b00, 3'b100, 12'h304, 32'h7, 5'd3, 1'b0, 32'h80, 5'd0, 0, 1'b0, 32'h0, 1'b1, 32'h10, 3);
    // Immediate forms on mie, rd = x0 suppresses the writeback
    push_op(OP_RW, 12'h304, 32'h5);
    send(2'b00, 3'b101, 12'h304, 32'hFFFF, 5'd5, 1'b1, 32'h84, 5'd0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 3);
    push_op(OP_RC, 12'h304, 32'h1);
    send(2'b00, 3'b111, 12'h304, 32'hFFFF, 5'd1, 1'b0, 32'h88, 5'd0, 0, 1'b1, 32'h5, 1'b0, 32'h0, 3);
    // Backpressure: response held for 4 cycles
    push_op(OP_RS, 12'h304, 32'h18);
    send(2'b00, 3'b110, 12'h304, 32'h0, 5'h18, 1'b0, 32'h8C, 5'd0, 4, 1'b1, 32'h4, 1'b0, 32'h0, 3);
    push_op(OP_RC, 12'h304, 32'hFFFF_FFF0);
    send(2'b00, 3'b011, 12'h304, 32'hFFFF_FFF0, 5'd0, 1'b0, 32'h90, 5'd0, 0, 1'b1, 32'h1C, 1'b0, 32'h0, 3);

    // Reset while the op is being issued
    @(negedge clk); #1;
    push_op(OP_RW, 12'h300, 32'h55);
    req_kind = 2'b00; req_funct3 = 3'b001; req_csr = 12'h300; req_rs1_value = 32'h55;
    req_rd_zero = 1'b0; req_pc = 32'h94; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_req_ready", 64'(req_ready), 64'(1));
    check("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midreset_csr_op", 64'(csr_op), 64'(OP_IDLE));
    push_op(OP_RS, 12'h300, 32'h0);
    send(2'b00, 3'b010, 12'h300, 32'h0, 5'd0, 1'b0, 32'h98, 5'd0, 0, 1'b1, 32'h0, 1'b0, 32'h0, 3);

    repeat (5) @(negedge clk);
    check("pending_rsp", 64'(rsp_q.size()), 64'(0));
    check("pending_op", 64'(op_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
